// File: rtl/udp_check_pkg.sv
// Shared types, constants and the ones'-complement fold used by the UDP RX checksum checker.
package udp_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DROP,
    CHECK,
    HDR_OUT,
    PAY_OUT
  } state_t;

  localparam logic [7:0] UDP_PROTO   = 8'h11;
  localparam int         UDP_HDR_LEN = 8;

  // Two end-around folds bring any 32-bit accumulation back into 16 bits.
  function automatic logic [15:0] ones_fold(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
    return t[15:0];
  endfunction

endpackage

// File: rtl/udp_check_buf.sv
// Simple dual-port payload RAM with a registered, enable-gated read port.
module udp_check_buf #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // nothing downstream looks at rd_data until the pipeline valid says so.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_checksum_check.sv
// UDP RX checksum checker: buffers one frame, verifies the checksum, re-emits it with a verdict.
// Build option: define UDP_CHECKSUM_CHECK_DROP_EN to discard failing frames instead of forwarding them.
module udp_checksum_check
  import udp_check_pkg::*;
#(
  parameter int PAYLOAD_DEPTH = 2048,
  parameter int META_W        = 208
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_udp_hdr_valid,
  output logic              s_udp_hdr_ready,
  input  logic [META_W-1:0] s_hdr_meta,
  input  logic [31:0]       s_ip_source_ip,
  input  logic [31:0]       s_ip_dest_ip,
  input  logic [15:0]       s_udp_source_port,
  input  logic [15:0]       s_udp_dest_port,
  input  logic [15:0]       s_udp_length,
  input  logic [15:0]       s_udp_checksum,
  input  logic [7:0]        s_udp_payload_axis_tdata,
  input  logic              s_udp_payload_axis_tvalid,
  output logic              s_udp_payload_axis_tready,
  input  logic              s_udp_payload_axis_tlast,
  input  logic              s_udp_payload_axis_tuser,
  output logic              m_udp_hdr_valid,
  input  logic              m_udp_hdr_ready,
  output logic [META_W-1:0] m_hdr_meta,
  output logic [31:0]       m_ip_source_ip,
  output logic [31:0]       m_ip_dest_ip,
  output logic [15:0]       m_udp_source_port,
  output logic [15:0]       m_udp_dest_port,
  output logic [15:0]       m_udp_length,
  output logic [15:0]       m_udp_checksum,
  output logic              m_udp_checksum_ok,
  output logic [7:0]        m_udp_payload_axis_tdata,
  output logic              m_udp_payload_axis_tvalid,
  input  logic              m_udp_payload_axis_tready,
  output logic              m_udp_payload_axis_tlast,
  output logic              m_udp_payload_axis_tuser,
  output logic              busy,
  output logic              error_checksum,
  output logic              error_overflow
);

  localparam int AW = $clog2(PAYLOAD_DEPTH);
  localparam int CW = AW + 1;

  state_t        state;
  logic [CW-1:0] wr_cnt;
  logic [31:0]   sum;
  logic          tuser_lat;
  logic          checksum_ok_r;

  logic [CW-1:0] rd_ptr;
  logic          ram_valid;
  logic          ram_last;
  logic [7:0]    ram_data;
  logic          out_valid;
  logic          out_last;
  logic [7:0]    out_data;

  logic          hdr_fire;
  logic          in_fire;
  logic          out_fire;
  logic          out_take;
  logic          rd_en;
  logic          overflow;
  logic          buf_we;
  logic [31:0]   seed;
  logic [31:0]   sum_add;
  logic [16:0]   len_seen;
  logic          ok;

  assign hdr_fire = s_udp_hdr_valid && s_udp_hdr_ready;
  assign in_fire  = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
  assign overflow = (wr_cnt == CW'(PAYLOAD_DEPTH));
  assign buf_we   = in_fire && (state == ACCUM) && !overflow;
  assign busy     = (state != IDLE);

  // Payload is only exposed after the header handshake, although the pipeline prefetches during HDR_OUT.
  assign m_udp_payload_axis_tvalid = out_valid && (state == PAY_OUT);
  assign m_udp_payload_axis_tdata  = out_data;
  assign m_udp_payload_axis_tlast  = out_last;
  assign m_udp_payload_axis_tuser  = out_last && tuser_lat;

  assign out_fire = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
  assign out_take = ram_valid && (!out_valid || out_fire);
  assign rd_en    = ((state == HDR_OUT) || (state == PAY_OUT)) && (rd_ptr != wr_cnt)
                    && (!ram_valid || out_take);

  // NOTE: combinational blocks use blocking '=' and assign every output on every path,
  // so no latch can be inferred.
  always_comb begin
    seed = 32'(s_ip_source_ip[31:16]) + 32'(s_ip_source_ip[15:0])
         + 32'(s_ip_dest_ip[31:16]) + 32'(s_ip_dest_ip[15:0])
         + 32'(UDP_PROTO) + 32'(s_udp_length)
         + 32'(s_udp_source_port) + 32'(s_udp_dest_port)
         + 32'(s_udp_length) + 32'(s_udp_checksum);
    sum_add  = wr_cnt[0] ? {24'h0, s_udp_payload_axis_tdata}
                         : {16'h0, s_udp_payload_axis_tdata, 8'h0};
    len_seen = 17'(wr_cnt) + 17'(UDP_HDR_LEN);
    ok       = (len_seen == {1'b0, m_udp_length})
               && ((ones_fold(sum) == 16'hFFFF) || (m_udp_checksum == 16'h0));
  end

`ifdef UDP_CHECKSUM_CHECK_DROP_EN
  assign m_udp_checksum_ok = 1'b1;
`else
  assign m_udp_checksum_ok = checksum_ok_r;
`endif

  // NOTE: registers update with non-blocking '<=' so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      s_udp_hdr_ready           <= 1'b0;
      s_udp_payload_axis_tready <= 1'b0;
      m_udp_hdr_valid           <= 1'b0;
      error_checksum            <= 1'b0;
      error_overflow            <= 1'b0;
      checksum_ok_r             <= 1'b0;
      wr_cnt                    <= '0;
      sum                       <= '0;
      tuser_lat                 <= 1'b0;
      m_hdr_meta                <= '0;
      m_ip_source_ip            <= '0;
      m_ip_dest_ip              <= '0;
      m_udp_source_port         <= '0;
      m_udp_dest_port           <= '0;
      m_udp_length              <= '0;
      m_udp_checksum            <= '0;
    end else begin
      error_checksum <= 1'b0;
      error_overflow <= 1'b0;
      case (state)
        IDLE: begin
          s_udp_hdr_ready <= 1'b1;
          if (hdr_fire) begin
            m_hdr_meta                <= s_hdr_meta;
            m_ip_source_ip            <= s_ip_source_ip;
            m_ip_dest_ip              <= s_ip_dest_ip;
            m_udp_source_port         <= s_udp_source_port;
            m_udp_dest_port           <= s_udp_dest_port;
            m_udp_length              <= s_udp_length;
            m_udp_checksum            <= s_udp_checksum;
            sum                       <= seed;
            wr_cnt                    <= '0;
            s_udp_hdr_ready           <= 1'b0;
            s_udp_payload_axis_tready <= 1'b1;
            state                     <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            if (overflow) begin
              error_overflow <= 1'b1;
              if (s_udp_payload_axis_tlast) begin
                s_udp_payload_axis_tready <= 1'b0;
                state                     <= IDLE;
              end else begin
                state <= DROP;
              end
            end else begin
              sum    <= sum + sum_add;
              wr_cnt <= wr_cnt + CW'(1);
              if (s_udp_payload_axis_tlast) begin
                tuser_lat                 <= s_udp_payload_axis_tuser;
                s_udp_payload_axis_tready <= 1'b0;
                state                     <= CHECK;
              end
            end
          end
        end
        DROP: begin
          if (in_fire && s_udp_payload_axis_tlast) begin
            s_udp_payload_axis_tready <= 1'b0;
            state                     <= IDLE;
          end
        end
        CHECK: begin
          checksum_ok_r  <= ok;
          error_checksum <= !ok;
`ifdef UDP_CHECKSUM_CHECK_DROP_EN
          if (!ok) begin
            wr_cnt <= '0;
            sum    <= '0;
            state  <= IDLE;
          end else begin
            m_udp_hdr_valid <= 1'b1;
            state           <= HDR_OUT;
          end
`else
          m_udp_hdr_valid <= 1'b1;
          state           <= HDR_OUT;
`endif
        end
        HDR_OUT: begin
          if (m_udp_hdr_ready) begin
            m_udp_hdr_valid <= 1'b0;
            state           <= PAY_OUT;
          end
        end
        PAY_OUT: begin
          if (out_fire && out_last) begin
            wr_cnt <= '0;
            sum    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage read pipeline: RAM output stage plus output register, both stallable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (state == IDLE) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr   <= rd_ptr + CW'(1);
        ram_last <= (rd_ptr == wr_cnt - CW'(1));
      end
      if (rd_en)         ram_valid <= 1'b1;
      else if (out_take) ram_valid <= 1'b0;
      if (out_take) begin
        out_valid <= 1'b1;
        out_data  <= ram_data;
        out_last  <= ram_last;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  udp_check_buf #(
    .DEPTH (PAYLOAD_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (s_udp_payload_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_data)
  );

endmodule

// File: tb/tb_udp_checksum_check.sv
// Self-checking bench for udp_checksum_check (default build, 16-byte buffer) against a ones'-complement model.
module tb_udp_checksum_check;

  localparam int DEPTH  = 16;
  localparam int META_W = 208;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_udp_hdr_valid = 1'b0;
  logic              s_udp_hdr_ready;
  logic [META_W-1:0] s_hdr_meta = '0;
  logic [31:0]       s_ip_source_ip = '0;
  logic [31:0]       s_ip_dest_ip = '0;
  logic [15:0]       s_udp_source_port = '0;
  logic [15:0]       s_udp_dest_port = '0;
  logic [15:0]       s_udp_length = '0;
  logic [15:0]       s_udp_checksum = '0;
  logic [7:0]        s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic              s_tuser = 1'b0;
  logic              m_udp_hdr_valid;
  logic              m_udp_hdr_ready = 1'b0;
  logic [META_W-1:0] m_hdr_meta;
  logic [31:0]       m_ip_source_ip;
  logic [31:0]       m_ip_dest_ip;
  logic [15:0]       m_udp_source_port;
  logic [15:0]       m_udp_dest_port;
  logic [15:0]       m_udp_length;
  logic [15:0]       m_udp_checksum;
  logic              m_udp_checksum_ok;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              m_tuser;
  logic              busy;
  logic              error_checksum;
  logic              error_overflow;

  udp_checksum_check #(
    .PAYLOAD_DEPTH (DEPTH),
    .META_W        (META_W)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_udp_hdr_valid           (s_udp_hdr_valid),
    .s_udp_hdr_ready           (s_udp_hdr_ready),
    .s_hdr_meta                (s_hdr_meta),
    .s_ip_source_ip            (s_ip_source_ip),
    .s_ip_dest_ip              (s_ip_dest_ip),
    .s_udp_source_port         (s_udp_source_port),
    .s_udp_dest_port           (s_udp_dest_port),
    .s_udp_length              (s_udp_length),
    .s_udp_checksum            (s_udp_checksum),
    .s_udp_payload_axis_tdata  (s_tdata),
    .s_udp_payload_axis_tvalid (s_tvalid),
    .s_udp_payload_axis_tready (s_tready),
    .s_udp_payload_axis_tlast  (s_tlast),
    .s_udp_payload_axis_tuser  (s_tuser),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_hdr_meta                (m_hdr_meta),
    .m_ip_source_ip            (m_ip_source_ip),
    .m_ip_dest_ip              (m_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_checksum_ok         (m_udp_checksum_ok),
    .m_udp_payload_axis_tdata  (m_tdata),
    .m_udp_payload_axis_tvalid (m_tvalid),
    .m_udp_payload_axis_tready (m_tready),
    .m_udp_payload_axis_tlast  (m_tlast),
    .m_udp_payload_axis_tuser  (m_tuser),
    .busy                      (busy),
    .error_checksum            (error_checksum),
    .error_overflow            (error_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_cks = 0;
  int n_ovf = 0;
  logic [7:0] pay[$];
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Counts high cycles, so a pulse longer than one cycle shows up as extra counts.
  always @(negedge clk) begin
    if (error_checksum === 1'b1) n_cks <= n_cks + 1;
    if (error_overflow === 1'b1) n_ovf <= n_ovf + 1;
  end

  task automatic check(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int oc_add(input int a, input int b);
    int s;
    s = a + b;
    if (s > 32'hFFFF) s = s - 32'hFFFF;
    return s;
  endfunction

  // Ones'-complement sum over pseudo-header, header and payload words (odd tail padded low).
  function automatic int ref_sum(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [15:0] sp, input logic [15:0] dp,
                                 input logic [15:0] len, input logic [15:0] ck);
    int acc;
    int w;
    acc = 0;
    acc = oc_add(acc, int'(src[31:16]));
    acc = oc_add(acc, int'(src[15:0]));
    acc = oc_add(acc, int'(dst[31:16]));
    acc = oc_add(acc, int'(dst[15:0]));
    acc = oc_add(acc, 17);
    acc = oc_add(acc, int'(len));
    acc = oc_add(acc, int'(sp));
    acc = oc_add(acc, int'(dp));
    acc = oc_add(acc, int'(len));
    acc = oc_add(acc, int'(ck));
    for (int i = 0; i < pay.size(); i += 2) begin
      w = int'(pay[i]) * 256;
      if (i + 1 < pay.size()) w = w + int'(pay[i+1]);
      acc = oc_add(acc, w);
    end
    return acc;
  endfunction

  task automatic send_hdr(input string tag);
    int t;
    t = 0;
    s_udp_hdr_valid = 1'b1;
    while (!s_udp_hdr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check({tag, "_hdr_accept_timeout"}, 1'b0, 1'b1);
    @(negedge clk);
    s_udp_hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input string tag, input bit gaps, input bit user, input int n_send,
                              output int last_cyc);
    int t;
    last_cyc = 0;
    for (int i = 0; i < n_send; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = pay[i];
      s_tlast  = (i == pay.size() - 1);
      s_tuser  = user && (i == pay.size() - 1);
      t = 0;
      while (!s_tready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        check({tag, "_byte_accept_timeout"}, 1'b0, 1'b1);
        s_tvalid = 1'b0;
        break;
      end
      last_cyc = cyc;
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input logic [15:0] len, input logic [15:0] ck,
                           input bit user, input bit gaps, input bit throttle);
    int          last_cyc;
    int          t;
    int          cks0;
    int          ovf0;
    int          bubbles;
    int          bad_user;
    int          seen;
    bit          started;
    bit          done;
    bit          exp_ok;
    bit          last_user;
    logic [META_W-1:0] meta;

    for (int i = 0; i < META_W / 8; i++) meta[i*8 +: 8] = 8'($urandom);
    exp_ok = (int'(len) == pay.size() + 8) && (ref_sum(src, dst, sp, dp, len, ck) == 32'hFFFF || ck == 16'h0);
    s_hdr_meta        = meta;
    s_ip_source_ip    = src;
    s_ip_dest_ip      = dst;
    s_udp_source_port = sp;
    s_udp_dest_port   = dp;
    s_udp_length      = len;
    s_udp_checksum    = ck;
    cks0 = n_cks;
    ovf0 = n_ovf;

    send_hdr(tag);
    send_payload(tag, gaps, user, pay.size(), last_cyc);

    if (pay.size() > DEPTH) begin
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        m_tready = 1'b1;
        if (m_udp_hdr_valid || m_tvalid) seen++;
        @(negedge clk);
      end
      m_tready = 1'b0;
      check({tag, "_no_output"}, seen, 0);
      check({tag, "_overflow_pulses"}, n_ovf - ovf0, 1);
      check({tag, "_checksum_pulses"}, n_cks - cks0, 0);
      check({tag, "_busy_after"}, busy, 1'b0);
      return;
    end

    t = 0;
    while (!m_udp_hdr_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      check({tag, "_hdr_valid_timeout"}, 1'b0, 1'b1);
      return;
    end
    check({tag, "_latency"}, cyc - last_cyc, 2);
    check({tag, "_hdr_fields"}, {m_ip_source_ip, m_ip_dest_ip, m_udp_source_port, m_udp_dest_port,
                                 m_udp_length, m_udp_checksum}, {src, dst, sp, dp, len, ck});
    check({tag, "_meta"}, m_hdr_meta, meta);
    check({tag, "_ok"}, m_udp_checksum_ok, exp_ok);

    t = $urandom_range(0, 2);
    for (int i = 0; i < t; i++) @(negedge clk);
    if (t > 0) check({tag, "_hdr_valid_held"}, m_udp_hdr_valid, 1'b1);
    m_udp_hdr_ready = 1'b1;
    @(negedge clk);
    m_udp_hdr_ready = 1'b0;

    got.delete();
    bubbles   = 0;
    bad_user  = 0;
    started   = 1'b0;
    done      = 1'b0;
    last_user = 1'b0;
    t = 0;
    while (!done && t < 400) begin
      m_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        got.push_back(m_tdata);
        started = 1'b1;
        if (m_tlast) begin
          done      = 1'b1;
          last_user = m_tuser;
        end else if (m_tuser) begin
          bad_user++;
        end
      end else if (started && !throttle) begin
        bubbles++;
      end
      @(negedge clk);
      t++;
    end
    m_tready = 1'b0;
    if (!done) check({tag, "_payload_timeout"}, 1'b0, 1'b1);
    check({tag, "_byte_count"}, got.size(), pay.size());
    for (int i = 0; i < got.size() && i < pay.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], pay[i]);
    check({tag, "_tuser_last"}, last_user, user);
    check({tag, "_tuser_early"}, bad_user, 0);
    if (!throttle) check({tag, "_bubbles"}, bubbles, 0);
    check({tag, "_checksum_pulses"}, n_cks - cks0, exp_ok ? 0 : 1);
    check({tag, "_overflow_pulses"}, n_ovf - ovf0, 0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    int          n;
    int          kind;
    int          dummy;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] ck;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_hdr_valid", m_udp_hdr_valid, 1'b0);
    check("reset_pay_valid", m_tvalid, 1'b0);
    check("reset_in_tready", s_tready, 1'b0);
    check("reset_ok", m_udp_checksum_ok, 1'b0);
    check("reset_errors", {error_checksum, error_overflow}, 2'b00);
    check("reset_hdr_regs", {m_ip_source_ip, m_udp_length, m_udp_checksum}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("good", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd12, 16'hC303, 1'b0, 1'b0, 1'b0);
    run_frame("bad_ck", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd12, 16'hC304, 1'b0, 1'b0, 1'b0);
    fill_pay(7);
    run_frame("zero_ck", 32'h0A000001, 32'h0A000002, 16'h1111, 16'h2222, 16'd15, 16'h0000, 1'b0, 1'b1, 1'b0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("bad_len", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd13, 16'hC303, 1'b0, 1'b0, 1'b0);
    fill_pay(20);
    run_frame("overflow", 32'h01020304, 32'h05060708, 16'h0001, 16'h0002, 16'd28, 16'h0000, 1'b0, 1'b0, 1'b0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("after_ovf", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd12, 16'hC303, 1'b0, 1'b0, 1'b0);
    fill_pay(DEPTH);
    ck = 16'(~ref_sum(32'h0A0B0C0D, 32'h01020304, 16'h3039, 16'h0035, 16'(DEPTH + 8), 16'h0));
    run_frame("full_buf", 32'h0A0B0C0D, 32'h01020304, 16'h3039, 16'h0035, 16'(DEPTH + 8), ck, 1'b0, 1'b0, 1'b0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("throttle", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd12, 16'hC303, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of ACCUM after three bytes.
    s_ip_source_ip = 32'hC0A80164;
    s_udp_length   = 16'd12;
    send_hdr("mid_rst");
    send_payload("mid_rst", 1'b0, 1'b0, 3, dummy);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_outputs", {m_udp_hdr_valid, m_tvalid, s_tready, s_udp_hdr_ready,
                              m_udp_checksum_ok, error_checksum, error_overflow}, 7'h0);
    check("mid_rst_hdr_regs", {m_ip_source_ip, m_udp_length}, 48'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("post_rst", 32'hC0A80164, 32'hC0A80180, 16'h04D2, 16'h162E, 16'd12, 16'hC303, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 9);
      n    = (kind == 9) ? $urandom_range(DEPTH + 1, DEPTH + 8) : $urandom_range(1, DEPTH);
      fill_pay(n);
      src = $urandom;
      dst = $urandom;
      sp  = 16'($urandom);
      dp  = 16'($urandom);
      ck  = 16'(~ref_sum(src, dst, sp, dp, 16'(n + 8), 16'h0));
      if (kind == 6) ck = 16'($urandom);
      if (kind == 7) ck = 16'h0;
      run_frame($sformatf("rand%0d", f), src, dst, sp, dp,
                (kind == 8) ? 16'(n + 9) : 16'(n + 8), ck,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udp_checksum_check.md
Name: udp_checksum_check

Overview:
- RX-side counterpart of the UDP TX checksum generator; sits between the UDP-from-IP receiver and the UDP application.
- Stores each received UDP frame (header + payload) in an internal buffer, one frame at a time.
- Computes the ones'-complement sum over pseudo-header, UDP header and payload, then re-emits header and payload with a checksum verdict.

Parameters:
PAYLOAD_DEPTH, 2048, payload buffer bytes; power of two, ≥16
META_W, 208, width of opaque eth/IP sideband passed through unchanged

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_udp_hdr_valid  input  1  header valid
s_udp_hdr_ready  output  1  header ready
s_hdr_meta  input  META_W  eth/IP fields, passed through unchanged
s_ip_source_ip  input  32  pseudo-header source IP
s_ip_dest_ip  input  32  pseudo-header destination IP
s_udp_source_port  input  16  UDP source port
s_udp_dest_port  input  16  UDP destination port
s_udp_length  input  16  UDP length (header + payload)
s_udp_checksum  input  16  received checksum
s_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  payload stream
m_udp_hdr_valid  output  1  header valid
m_udp_hdr_ready  input  1  header ready
m_hdr_meta, m_ip_source_ip, m_ip_dest_ip, m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum  output  as s_  latched header copy
m_udp_checksum_ok  output  1  verdict, valid with m_udp_hdr_valid
m_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  payload stream
busy  output  1  high in any state but IDLE
error_checksum  output  1  one-cycle pulse on failed check
error_overflow  output  1  one-cycle pulse on buffer overflow

Behaviour:
- Reset (async): state IDLE; all valids, tready, error pulses and checksum_ok = 0; pointers, counters and sum = 0; output header registers = 0. Reset mid-frame discards the buffered frame.
- States: IDLE, ACCUM, DROP, CHECK, HDR_OUT, PAY_OUT.
- IDLE:
  - s_udp_hdr_ready = 1.
  - On handshake: latch all header fields and seed the 32-bit sum with: src_ip[31:16] + src_ip[15:0] + dst_ip[31:16] + dst_ip[15:0] + 16'h0011 + udp_length + src_port + dst_port + udp_length + checksum.
  - Go to ACCUM.
- ACCUM:
  - s_udp_payload_axis_tready = 1.
  - Each accepted byte is written to buffer[wr_cnt].
  - Even wr_cnt adds byte<<8 to the sum; odd wr_cnt adds byte.
  - wr_cnt increments per byte.
  - On tlast: latch tuser, go to CHECK.
  - If a byte arrives with wr_cnt == PAYLOAD_DEPTH: discard it, pulse error_overflow, go to DROP (or straight to IDLE if that byte has tlast).
- DROP: tready = 1; consume and discard until tlast, then IDLE. No output is produced.
- CHECK (exactly one cycle):
  - Fold the sum twice: f = s[15:0] + s[31:16].
  - ok = (udp_length == wr_cnt + 8) && (f == 16'hFFFF || received checksum == 0).
  - ok = 0 pulses error_checksum; then go to HDR_OUT.
- HDR_OUT: m_udp_hdr_valid = 1 with latched fields held stable; on m_udp_hdr_ready go to PAY_OUT.
- PAY_OUT:
  - Buffer read is registered (1-cycle); an output skid register prefetches, so the stream sustains 1 byte/cycle with no bubbles under continuous tready.
  - tlast asserts on byte wr_cnt-1; tuser = latched tuser, asserted on the last byte only.
  - After the last handshake: clear counters, go to IDLE.
- Latency: header valid 2 cycles after the last input byte is accepted.
- Input is never accepted while output is in progress (no overlap between frames).
- Sum is 32 bits; no overflow possible for PAYLOAD_DEPTH ≤ 65535.

Optional Feature:
UDP_CHECKSUM_CHECK_DROP_EN
- Defined: a failing frame (ok = 0) goes CHECK→IDLE, emits no header or payload, and pulses error_checksum; m_udp_checksum_ok is tied to 1.
- Undefined: every frame is forwarded and ok is reported on m_udp_checksum_ok.

Decomposition:
- Package udp_check_pkg: state enum, UDP_PROTO = 8'h11, UDP_HDR_LEN = 8, ones'-complement fold function.
- One sub-module, udp_check_buf: simple dual-port RAM, PAYLOAD_DEPTH×8, registered read.

Test Plan:
- Good frame: src C0A80164, dst C0A80180, ports 04D2→162E, length 12, checksum C303, payload DE AD BE EF → header out with ok = 1, bytes DE AD BE EF, tlast on EF, error_checksum stays 0.
- Same frame with checksum C304 → ok = 0 and a one-cycle error_checksum pulse; with UDP_CHECKSUM_CHECK_DROP_EN, no output at all.
- Checksum 0000 with any payload → ok = 1; length 13 with a 4-byte payload → ok = 0.
- PAYLOAD_DEPTH = 16, 20-byte frame → error_overflow pulses once, all 20 bytes consumed, no output, next frame processed normally.
- Good frame with random m_udp_payload_axis_tready throttling → identical byte order, no duplicates; tuser = 1 on input last byte → tuser = 1 on output last byte.
- Assert rst during ACCUM after 3 bytes → all outputs 0 immediately, busy = 0; a following good frame passes with ok = 1.
